// File: rtl/regfile_dbg_master.sv
// Debug initiator for the CPU regfile: READ, WRITE (+readback), DUMP x0..x31, CLEAR x1..x31.
// Latency: READ has rsp_valid 3 cycles after grant (GRANT, RADDR, RCAP, then RSP). WRITE adds one WR cycle.
// Backpressure: cmd_ready only in IDLE; RSP holds until rsp_ready; rf_grant low freezes the walk.
// Optional macro REGFILE_DBG_TIMEOUT_EN adds an error response when no grant arrives in time.
module regfile_dbg_master #(
   parameter int XLEN          = 32,
   parameter int NREGS         = 32,
   parameter int GRANT_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [4:0]      cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [4:0]      rsp_addr,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_last,
   output logic            rsp_err,
   output logic            dbg_active,
   input  logic            rf_grant,
   output logic [4:0]      rf_rs1,
   input  logic [XLEN-1:0] rf_rd1,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wd
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_RADDR = 3'd2;
   localparam logic [2:0] S_RCAP  = 3'd3;
   localparam logic [2:0] S_RSP   = 3'd4;
   localparam logic [2:0] S_WR    = 3'd5;
   localparam logic [2:0] S_CLR   = 3'd6;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_DUMP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

   logic [2:0]      state;
   logic [1:0]      op_q;
   logic [4:0]      addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [4:0]      clr_idx;
   logic [4:0]      rs1_q;
   logic [XLEN-1:0] cap_q;
   logic [4:0]      rsp_addr_q;
   logic [XLEN-1:0] rsp_data_q;
   logic            rsp_last_q;
   logic            wr_fire;

`ifdef REGFILE_DBG_TIMEOUT_EN
   logic [7:0]      tmo_cnt;
   logic            rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Writes only happen in WR (never to x0) and CLR, and only while the port is granted.
   assign wr_fire    = rf_grant && (((state == S_WR) && (addr_q != 5'd0)) || (state == S_CLR));
   assign rf_we      = wr_fire;
   assign rf_rd      = !wr_fire ? 5'd0 : ((state == S_CLR) ? clr_idx : addr_q);
   assign rf_wd      = (wr_fire && (state == S_WR)) ? wdata_q : '0;
   // cmd_ready is gated by reset so every output reads 0 while reset is held.
   assign cmd_ready  = (state == S_IDLE) && !reset;
   assign dbg_active = (state != S_IDLE);
   assign rsp_valid  = (state == S_RSP);
   assign rf_rs1     = rs1_q;
   assign rsp_addr   = rsp_addr_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_last   = rsp_last_q;

   // Command sequencer: every step past GRANT stalls in place while rf_grant is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= 2'b00;
         addr_q     <= 5'd0;
         wdata_q    <= '0;
         clr_idx    <= 5'd0;
         rs1_q      <= 5'd0;
         cap_q      <= '0;
         rsp_addr_q <= 5'd0;
         rsp_data_q <= '0;
         rsp_last_q <= 1'b0;
`ifdef REGFILE_DBG_TIMEOUT_EN
         tmo_cnt    <= 8'd0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  state   <= S_GRANT;
`ifdef REGFILE_DBG_TIMEOUT_EN
                  tmo_cnt   <= 8'd0;
                  rsp_err_q <= 1'b0;
`endif
               end
            end
            S_GRANT: begin
               if (rf_grant) begin
                  case (op_q)
                     OP_READ: begin
                        rs1_q <= addr_q;
                        state <= S_RADDR;
                     end
                     OP_WRITE: state <= S_WR;
                     OP_DUMP: begin
                        addr_q <= 5'd0;
                        rs1_q  <= 5'd0;
                        state  <= S_RADDR;
                     end
                     default: begin
                        clr_idx <= 5'd1;
                        state   <= S_CLR;
                     end
                  endcase
`ifdef REGFILE_DBG_TIMEOUT_EN
               end else if (tmo_cnt == 8'(GRANT_TIMEOUT - 1)) begin
                  // Give up without touching the regfile; report against the command address.
                  rsp_err_q  <= 1'b1;
                  rsp_addr_q <= addr_q;
                  rsp_data_q <= '0;
                  rsp_last_q <= 1'b1;
                  state      <= S_RSP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
`endif
               end
            end
            S_WR: begin
               if (rf_grant) begin
                  rs1_q <= addr_q;
                  state <= S_RADDR;
               end
            end
            S_RADDR: begin
               if (rf_grant) begin
                  cap_q <= (rs1_q == 5'd0) ? '0 : rf_rd1;
                  state <= S_RCAP;
               end
            end
            S_RCAP: begin
               if (rf_grant) begin
                  rsp_addr_q <= rs1_q;
                  rsp_data_q <= cap_q;
                  rsp_last_q <= (op_q != OP_DUMP) || (rs1_q == LAST_REG);
                  state      <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  if (rsp_last_q) begin
                     state <= S_IDLE;
                  end else begin
                     addr_q <= addr_q + 5'd1;
                     rs1_q  <= addr_q + 5'd1;
                     state  <= S_RADDR;
                  end
               end
            end
            S_CLR: begin
               if (rf_grant) begin
                  if (clr_idx == LAST_REG) begin
                     rsp_addr_q <= LAST_REG;
                     rsp_data_q <= XLEN'(NREGS - 1);
                     rsp_last_q <= 1'b1;
                     state      <= S_RSP;
                  end else begin
                     clr_idx <= clr_idx + 5'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dbg_master.sv
// Bench for regfile_dbg_master: behavioural regfile, response scoreboard, vector table.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls and rf_grant drops.
module tb_regfile_dbg_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_addr;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic        dbg_active;
   logic        rf_grant;
   logic [4:0]  rf_rs1;
   logic [31:0] rf_rd1;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;

   always #5 clk = ~clk;

   regfile_dbg_master dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .dbg_active(dbg_active), .rf_grant(rf_grant),
      .rf_rs1(rf_rs1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic        l;
      logic        e;
   } rsp_t;

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_we;
   } vec_t;

   rsp_t        exp_q[$];
   vec_t        vecs[8];
   logic [31:0] rf[32];
   int          checks = 0;
   int          errors = 0;
   int          we_cnt = 0;
   int          bad_we = 0;
   logic [4:0]  last_rd;
   logic [31:0] last_wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Behavioural regfile: x0 reads as zero; writes watched for illegal cases.
   assign rf_rd1 = (rf_rs1 == 5'd0) ? 32'h0 : rf[rf_rs1];

   always @(posedge clk) begin
      if (rf_we) begin
         rf[rf_rd] <= rf_wd;
         we_cnt++;
         last_rd = rf_rd;
         last_wd = rf_wd;
         if (!rf_grant || rf_rd == 5'd0) bad_we++;
      end
   end

   // Scoreboard: compare each response handshake with the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp_addr", {27'd0, rsp_addr}, 32'hFFFF_FFFF);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_addr", {27'd0, rsp_addr}, {27'd0, e.a});
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, e.l});
            chk("rsp_err",  {31'd0, rsp_err},  {31'd0, e.e});
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
      bit ok = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input bit jit);
      bit ok = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (jit) rf_grant = ($urandom_range(0, 3) != 0);
         if (exp_q.size() == 0 && cmd_ready) begin ok = 1; break; end
      end
      rf_grant = 1'b1;
      if (!ok) begin
         chk("idle_timeout", 32'd0, 32'd1);
         exp_q.delete();
      end
   endtask

   initial begin
      int w0;
      int n;
      bit seen;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      vecs[0] = '{2'b01, 5'd5,  32'hAAAA_BBBB, 32'hAAAA_BBBB, 1};
      vecs[1] = '{2'b01, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000, 0};
      vecs[2] = '{2'b00, 5'd5,  32'h0,         32'hAAAA_BBBB, 0};
      vecs[3] = '{2'b01, 5'd31, 32'h1234_5678, 32'h1234_5678, 1};
      vecs[4] = '{2'b00, 5'd31, 32'h0,         32'h1234_5678, 0};
      vecs[5] = '{2'b00, 5'd0,  32'h0,         32'h0000_0000, 0};
      vecs[6] = '{2'b01, 5'd1,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
      vecs[7] = '{2'b00, 5'd1,  32'h0,         32'hDEAD_BEEF, 0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 5'd0; cmd_wdata = 32'h0;
      rsp_ready = 1'b1; rf_grant = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_ready",  {31'd0, cmd_ready},  32'd0);
      chk("reset_dbg_active", {31'd0, dbg_active}, 32'd0);
      chk("reset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      chk("reset_rf_we",      {31'd0, rf_we},      32'd0);
      chk("reset_rf_rs1",     {27'd0, rf_rs1},     32'd0);
      chk("reset_rsp_data",   rsp_data,            32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

      // Table of single READ/WRITE commands with grant held high.
      for (int i = 0; i < 8; i++) begin
         w0 = we_cnt;
         exp_q.push_back('{vecs[i].addr, vecs[i].exp_data, 1'b1, 1'b0});
         send(vecs[i].op, vecs[i].addr, vecs[i].wdata);
         wait_idle(0);
         chk($sformatf("vec%0d_we_pulses", i), we_cnt - w0, vecs[i].exp_we);
         if (vecs[i].exp_we == 1) begin
            chk($sformatf("vec%0d_rf_rd", i), {27'd0, last_rd}, {27'd0, vecs[i].addr});
            chk($sformatf("vec%0d_rf_wd", i), last_wd, vecs[i].wdata);
         end
      end

      // READ latency: rsp_valid in the 4th cycle after acceptance (grant already high).
      exp_q.push_back('{5'd5, 32'hAAAA_BBBB, 1'b1, 1'b0});
      send(2'b00, 5'd5, 32'h0);
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (rsp_valid) break;
         n++;
      end
      chk("read_latency", n, 3);
      wait_idle(0);

      // Response stall: data held stable, then cmd_ready the cycle after handshake.
      rsp_ready = 1'b0;
      exp_q.push_back('{5'd5, 32'hAAAA_BBBB, 1'b1, 1'b0});
      send(2'b00, 5'd5, 32'h0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_rsp_data", rsp_data, 32'hAAAA_BBBB);
         chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      wait_idle(0);

      // Preload xN = N*0x11111111, then DUMP everything.
      for (int r = 1; r < 32; r++) begin
         exp_q.push_back('{5'(r), 32'(r) * 32'h1111_1111, 1'b1, 1'b0});
         send(2'b01, 5'(r), 32'(r) * 32'h1111_1111);
         wait_idle(0);
      end
      for (int r = 0; r < 32; r++)
         exp_q.push_back('{5'(r), 32'(r) * 32'h1111_1111, (r == 31), 1'b0});
      send(2'b10, 5'd9, 32'h0);
      wait_idle(0);

      // CLEAR with a jittering grant, then DUMP of zeros with jitter too.
      w0 = we_cnt;
      exp_q.push_back('{5'd31, 32'd31, 1'b1, 1'b0});
      send(2'b11, 5'd0, 32'h0);
      wait_idle(1);
      chk("clear_we_pulses", we_cnt - w0, 31);
      for (int r = 0; r < 32; r++)
         exp_q.push_back('{5'(r), 32'h0, (r == 31), 1'b0});
      send(2'b10, 5'd0, 32'h0);
      wait_idle(1);

      // Grant withheld for 300 cycles on a WRITE.
      w0 = we_cnt;
      rf_grant = 1'b0;
`ifdef REGFILE_DBG_TIMEOUT_EN
      exp_q.push_back('{5'd7, 32'h0, 1'b1, 1'b1});
      send(2'b01, 5'd7, 32'hDEAD_BEEF);
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         if (rsp_valid) break;
         n++;
      end
      chk("timeout_cycles", n, 255);
      wait_idle(0);
      chk("timeout_no_we", we_cnt - w0, 0);
`else
      send(2'b01, 5'd7, 32'hDEAD_BEEF);
      seen = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      chk("nogrant_no_rsp", {31'd0, seen}, 32'd0);
      chk("nogrant_active", {31'd0, dbg_active}, 32'd1);
      chk("nogrant_no_we", we_cnt - w0, 0);
      exp_q.push_back('{5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0});
      @(posedge clk); #1 rf_grant = 1'b1;
      wait_idle(0);
      chk("late_grant_we", we_cnt - w0, 1);
`endif
      rf_grant = 1'b1;

      // Reset in the middle of a DUMP aborts it cleanly.
      for (int r = 0; r < 32; r++)
         exp_q.push_back('{5'(r), rf[r], (r == 31), 1'b0});
      send(2'b10, 5'd0, 32'h0);
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         if (exp_q.size() <= 28) break;
      end
      #1 reset = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      chk("midreset_dbg_active", {31'd0, dbg_active}, 32'd0);
      chk("midreset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      chk("midreset_rf_we",      {31'd0, rf_we},      32'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("after_reset_ready", {31'd0, cmd_ready}, 32'd1);

      chk("illegal_we", bad_we, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_dbg_master.md
Name: regfile_dbg_master

Overview:
- Debug-side initiator for the CPU register file. It sequences reads, writes, full dumps and a clear of x1..x31 over the regfile's rs1/rd1 and rd/wd/we ports.
- It sits between the debug command channel and the regfile port mux. It requests the port from the core with dbg_active and only drives the port while rf_grant is high.
- Responses return over a valid/ready channel.

Parameters:
- XLEN, 32, data width of regfile entries and of cmd_wdata/rsp_data
- NREGS, 32, number of architectural registers; address width is fixed at 5
- GRANT_TIMEOUT, 255, cycles to wait for rf_grant before an error response (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- cmd_addr  input  5  target register (READ/WRITE)
- cmd_wdata  input  XLEN  write data (WRITE)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_addr  output  5  register the response refers to
- rsp_data  output  XLEN  read or readback data; CLEAR returns the count of registers cleared
- rsp_last  output  1  final response of a command
- rsp_err  output  1  grant timeout error
- dbg_active  output  1  request and hold of the regfile port
- rf_grant  input  1  core has stalled and muxed the port to this block
- rf_rs1  output  5  regfile read address
- rf_rd1  input  XLEN  regfile read data, combinational from rf_rs1
- rf_we  output  1  regfile write enable
- rf_rd  output  5  regfile write address
- rf_wd  output  XLEN  regfile write data

Behaviour:
- Reset values (synchronous): every output 0; state IDLE; counters 0.
- cmd_ready=1 only in IDLE. A command is captured when cmd_valid && cmd_ready. Opcode, address and data are latched and go to GRANT.
- GRANT state:
  - dbg_active=1 from GRANT until the last response handshake completes.
  - Wait for rf_grant=1, then branch on the opcode.
  - If rf_grant drops mid-operation, the state holds: rf_we is forced 0 and no sampling occurs until grant returns.
- Read timing: rf_rs1 is registered. It is driven in RADDR; rf_rd1 is sampled on the next edge (RCAP). READ latency is 3 cycles from grant to rsp_valid.
- READ: RADDR -> RCAP -> RSP, with rsp_addr=addr, rsp_data=rf_rd1, rsp_last=1.
- WRITE:
  - WR: rf_we=1 for exactly one cycle with rf_rd=addr and rf_wd=wdata.
  - Then RADDR/RCAP read the same register back; RSP returns the readback value with rsp_last=1.
  - addr==0: rf_we is suppressed (stays 0); the readback returns 0.
- DUMP:
  - Walks x0..x31, one READ sequence per register.
  - Each register produces one response; rsp_last=1 only on x31.
  - The walk does not advance until each response handshakes.
- CLEAR:
  - Issues rf_we=1 on 31 consecutive granted cycles for x1..x31 with rf_wd=0. x0 is never written.
  - Then one response: rsp_addr=31, rsp_data=31, rsp_last=1.
- RSP state:
  - rsp_valid=1 and rsp_* are held stable until rsp_ready. On handshake: go to IDLE (last) or to the next DUMP step.
  - rsp_ready may be high before rsp_valid; the handshake completes in the first cycle rsp_valid=1.
  - rf_we=0 throughout RSP.
- rf_we is never asserted outside WR and CLEAR, and never while rf_grant=0.
- A reset mid-operation aborts the command: no further writes, all outputs 0, and the response is lost.
- A new command is never accepted while a response is pending; no back-to-back overlap.

Optional Feature:
- Macro: REGFILE_DBG_TIMEOUT_EN
- Defined:
  - An 8-bit counter runs in GRANT; it clears on entry and counts while rf_grant=0.
  - On reaching GRANT_TIMEOUT, the block goes to RSP with rsp_err=1, rsp_data=0, rsp_addr=cmd addr, rsp_last=1. No regfile access occurs.
  - For DUMP and CLEAR the timeout applies only to the initial grant.
- Undefined: GRANT waits indefinitely and rsp_err is tied 0.

Test Plan:
- Grant held high; WRITE addr=5, wdata=AAAABBBB -> one-cycle rf_we with rf_rd=5 and rf_wd=AAAABBBB. Response rsp_addr=5, rsp_data=AAAABBBB, rsp_last=1, rsp_err=0.
- WRITE addr=0, wdata=FFFFFFFF -> rf_we never asserted; response rsp_data=00000000.
- READ addr=5 after the write, rsp_ready low 4 cycles -> rsp_valid held with rsp_data=AAAABBBB stable; completes on the rsp_ready cycle; cmd_ready returns next cycle.
- Preload xN=N*0x11111111 then DUMP -> 32 responses, addr 0..31 in order; x0 data=0; rsp_last only on addr 31.
- CLEAR, then DUMP -> 31 rf_we pulses for addr 1..31, single response with rsp_data=31; the following dump returns all zeros.
- rf_grant low 300 cycles with REGFILE_DBG_TIMEOUT_EN defined -> error response after 255 cycles, rsp_err=1, no rf_we. Without the macro -> no response until grant, then a normal completion.
